// File: rtl/hex_display_pkg.sv
// Shared constants and glyph lookup for the HEX display driver.
//   SEG_BLANK     : all segments dark (active-low)
//   GLYPH_0..F    : active-low glyphs, segment a = bit 0 .. segment g = bit 6
//   seg_of(nib)   : nibble -> active-low glyph
package hex_display_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

  // Nibble to active-low 7-segment glyph.
  function automatic logic [SEG_W-1:0] seg_of(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational single-digit decoder.
//   nibble_i : hex digit to show
//   off_i    : force the digit dark
//   seg_o_c  : active-low segment word (combinational)
module hex_digit_decoder
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  input  logic             off_i,
  output logic [SEG_W-1:0] seg_o_c
);

  assign seg_o_c = off_i ? SEG_BLANK : seg_of(nibble_i);

endmodule

// File: rtl/hex_display_array.sv
// Multi-digit active-low 7-segment driver with load-captured value,
// leading-zero blanking, global blank and per-digit blinking.
//   clk, reset  : clock, async active-high reset
//   value       : packed nibbles, digit 0 least significant
//   load        : capture value; also restarts the blink prescaler visible
//   lz_en       : suppress leading zero digits (digit 0 always shown)
//   blank       : darken all digits
//   blink_mask  : per-digit blink enable, dark while the blink phase is high
//   hex         : registered active-low segments, 7 bits per digit
module hex_display_array
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        load,
  input  logic                        lz_en,
  input  logic                        blank,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [SEG_W*NUM_DIGITS-1:0] hex
);

  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
  localparam int unsigned HEX_W = SEG_W * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);

  logic [VAL_W-1:0]      held_q,  held_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  phase_q, phase_d;
  logic [HEX_W-1:0]      hex_q,   hex_d;

  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic [NUM_DIGITS-1:0] off_c;
  logic                  all_zero_c;

  // Holding register and blink prescaler; load wins over a same-cycle wrap.
  always_comb begin
    held_d  = held_q;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (load) begin
      held_d  = value;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // A digit is a leading zero when it and every more significant nibble is zero.
  always_comb begin
    lead_zero_c = '0;
    all_zero_c  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero_c     = all_zero_c & (held_q[NIB_W*i +: NIB_W] == '0);
      lead_zero_c[i] = all_zero_c & (i != 0);
    end
  end

  assign off_c = {NUM_DIGITS{blank}}
               | ({NUM_DIGITS{lz_en}} & lead_zero_c)
               | (blink_mask & {NUM_DIGITS{phase_q}});

  // One decoder per digit feeds the output register.
  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
    hex_digit_decoder u_dec (
      .nibble_i (held_q[NIB_W*g +: NIB_W]),
      .off_i    (off_c[g]),
      .seg_o_c  (hex_d[SEG_W*g +: SEG_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= '1;
    end else begin
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign hex = hex_q;

endmodule
